dmem_sram_bridge: RTL
=====================

DMEM_SRAM_BRIDGE -- requirements
Module: dmem_sram_bridge

Interface
REQ-001 Ports SHALL be, clock and reset first:
  clk  in  1  sole clock, all state on rising edge
  rst  in  1  asynchronous, active-low reset
  mem_en  in  1  MEM-stage access enable, already gated by flush and TLB valid
  mem_we  in  1  MEM-stage write (1) / read (0)
  mem_sel  in  4  byte enables from the MEM stage
  mem_size  in  2  0=byte, 1=half, 2=word
  mem_addr  in  32  physical data address
  mem_wdata  in  32  lane-aligned store data
  mem_flush  in  1  MEM-stage flush (exception/eret)
  mem_stall  in  1  pipeline MEM-stage stall from hazard unit
  mem_rdata  out  32  load data returned to MEM stage
  stallreq_from_mem  out  1  stall request to hazard unit
  data_req  out  1  SRAM-like bus request
  data_wr  out  1  bus write
  data_size  out  2  bus size, same encoding as mem_size
  data_addr  out  32  bus address
  data_wdata  out  32  bus write data
  data_wstrb  out  4  bus byte strobes
  data_addr_ok  in  1  request accepted this cycle
  data_data_ok  in  1  read data valid / write done this cycle
  data_rdata  in  32  bus read data
REQ-002 There SHALL be no parameters. Widths are fixed as listed.

Function
REQ-003 The FSM SHALL have four states: IDLE, ADDR, DATA and DONE. Reset state is IDLE.
REQ-004 IDLE with mem_en=1 and mem_flush=0 SHALL latch mem_addr, mem_we, mem_size, mem_wdata and mem_sel into request registers, then go to ADDR.
REQ-005 IDLE with mem_en=0 or mem_flush=1 SHALL remain in IDLE. No bus activity occurs.
REQ-006 data_req SHALL be 1 only in ADDR. data_wr, data_size, data_addr, data_wdata and data_wstrb SHALL come from the request registers and hold stable while data_req=1.
REQ-007 ADDR with data_addr_ok=1 SHALL go to DATA. If data_data_ok=1 in the same cycle, it SHALL go directly to DONE, or to IDLE when discarding.
REQ-008 ADDR with mem_flush=1 and data_addr_ok=0 SHALL cancel the request and return to IDLE. If data_addr_ok=1, the flush SHALL instead set the discard flag.
REQ-009 DATA with data_data_ok=1 SHALL go to DONE, or to IDLE if the discard flag is set. mem_flush in DATA SHALL set the discard flag. An outstanding transaction SHALL never be abandoned.
REQ-010 For a read that is not discarded, data_rdata SHALL be captured into mem_rdata on the data_data_ok cycle. mem_rdata SHALL hold that value until the next captured read.
REQ-011 DONE SHALL wait for the pipeline to advance: mem_stall=0 moves to IDLE; mem_stall=1 holds. No new request is issued from DONE.
REQ-012 stallreq_from_mem SHALL be combinational and equal (IDLE & mem_en & ~mem_flush) | ADDR | DATA. It SHALL be 0 in DONE.
REQ-013 The discard flag SHALL clear on entry to IDLE.
REQ-014 At most one transaction SHALL be outstanding. The block SHALL accept no new mem_en until it returns to IDLE.
REQ-015 Minimum latency SHALL be: request in cycle N, addr_ok and data_ok in cycle N+1, mem_rdata valid and stallreq 0 in cycle N+2.

Reset
REQ-016 While rst=0, the block SHALL hold the following values:
  state=IDLE, discard=0;
  data_req=0, data_wr=0, data_size=0, data_addr=0, data_wdata=0, data_wstrb=0;
  mem_rdata=0, request registers=0.
  stallreq_from_mem SHALL follow REQ-012 with state IDLE.
REQ-017 Reset asserted mid-transaction SHALL abort to IDLE immediately. Any later data_ok for that transaction SHALL be ignored in IDLE.

Verification
REQ-018 Read, zero-wait: mem_en=1, we=0, addr=0x1000, size=2; addr_ok=1 and data_ok=1 with rdata=0xDEADBEEF next cycle -> stallreq 1,1,0; mem_rdata=0xDEADBEEF; exactly one data_req cycle.
REQ-019 Byte write with back-pressure: we=1, sel=0100, wdata=0x00AB0000; addr_ok low 3 cycles, then 1; data_ok 2 cycles later -> data_req held 4 cycles with stable addr/wdata/wstrb=0100; stallreq held until DONE.
REQ-020 Flush before accept: mem_flush=1 in ADDR with addr_ok=0 -> IDLE next cycle; data_req drops; no transaction is counted.
REQ-021 Flush after accept: flush in DATA, data_ok with rdata=0x12345678 -> state IDLE; mem_rdata unchanged; stallreq held until data_ok.
REQ-022 Stall in DONE: mem_stall=1 for 3 cycles after completion -> no second data_req; stallreq=0; mem_rdata stable; IDLE once mem_stall=0.
REQ-023 Reset in DATA: rst=0 for 1 cycle -> all REQ-016 values; a later data_ok causes no state change.

Source files
------------

// File: rtl/dmem_sram_bridge.sv
// Bridges the MEM-stage data access onto an SRAM-like bus (addr_ok/data_ok handshake).
// Holds one transaction at a time and stalls the pipeline until it completes.
module dmem_sram_bridge (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_en,
   input  logic        mem_we,
   input  logic [3:0]  mem_sel,
   input  logic [1:0]  mem_size,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic        mem_flush,
   input  logic        mem_stall,
   output logic [31:0] mem_rdata,
   output logic        stallreq_from_mem,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   output logic [3:0]  data_wstrb,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

   state_t      state_reg, state_next;
   logic        discard_reg, discard_next;
   logic        req_we_reg;
   logic [1:0]  req_size_reg;
   logic [31:0] req_addr_reg;
   logic [31:0] req_wdata_reg;
   logic [3:0]  req_sel_reg;
   logic [31:0] rdata_reg;

   logic accept;
   logic resp_ok;
   logic drop;
   logic capture;

   assign accept  = (state_reg == IDLE) & mem_en & ~mem_flush;
   // Response only counts once the address phase has been accepted.
   assign resp_ok = data_data_ok &
                    (((state_reg == ADDR) & data_addr_ok) | (state_reg == DATA));
   assign drop    = discard_reg | mem_flush;
   assign capture = resp_ok & ~req_we_reg & ~drop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= IDLE;
         discard_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         discard_reg <= discard_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      discard_next = discard_reg;
      case (state_reg)
         IDLE: begin
            if (accept) state_next = ADDR;
         end
         ADDR: begin
            if (data_addr_ok) begin
               if (data_data_ok) begin
                  state_next = drop ? IDLE : DONE;
               end else begin
                  state_next = DATA;
                  if (mem_flush) discard_next = 1'b1;
               end
            end else if (mem_flush) begin
               state_next = IDLE;
            end
         end
         DATA: begin
            if (data_data_ok)   state_next   = drop ? IDLE : DONE;
            else if (mem_flush) discard_next = 1'b1;
         end
         DONE: begin
            if (!mem_stall) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (state_next == IDLE) discard_next = 1'b0;
   end

   always_comb begin
      data_req          = (state_reg == ADDR);
      stallreq_from_mem = accept | (state_reg == ADDR) | (state_reg == DATA);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_we_reg    <= 1'b0;
         req_size_reg  <= 2'd0;
         req_addr_reg  <= 32'd0;
         req_wdata_reg <= 32'd0;
         req_sel_reg   <= 4'd0;
         rdata_reg     <= 32'd0;
      end else begin
         if (accept) begin
            req_we_reg    <= mem_we;
            req_size_reg  <= mem_size;
            req_addr_reg  <= mem_addr;
            req_wdata_reg <= mem_wdata;
            req_sel_reg   <= mem_sel;
         end
         if (capture) rdata_reg <= data_rdata;
      end
   end

   assign data_wr    = req_we_reg;
   assign data_size  = req_size_reg;
   assign data_addr  = req_addr_reg;
   assign data_wdata = req_wdata_reg;
   assign data_wstrb = req_sel_reg;
   assign mem_rdata  = rdata_reg;

endmodule
